// File: rtl/regfile_pkg.sv
// Shared constants for the MIPS32 register-file writeback path.
// Requester indices define the arbiter's input ordering.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    localparam int WB_ALU     = 0;
    localparam int WB_LOAD    = 1;
    localparam int WB_MULDIV  = 2;
    localparam int NUM_WB_REQ = 3;

    // Width of an index into n requesters, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after i_ptr.
// The pointer register belongs to the parent.
module rr_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = NUM_WB_REQ,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    // Scan from lowest to highest priority so the nearest requester after ptr wins.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            int j;
            j = (int'(i_ptr) + k) % NUM_REQ;
            if (i_req[j]) begin
                o_idx = IDX_W'(j);
                o_any = 1'b1;
            end
        end
        if (o_any) o_gnt[o_idx] = 1'b1;
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between ALU, load and mul/div writeback.
// REGFILE_SCOREBOARD_EN builds the pending-destination scoreboard; otherwise o_pending is 0.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = NUM_WB_REQ,
    parameter int ADDR_W  = REG_ADDR_W,
    parameter int DATA_W  = REG_DATA_W
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
    output logic [NUM_REQ-1:0]        o_req_ready,
    output logic                      o_wr_en,
    output logic [ADDR_W-1:0]         o_wr_addr,
    output logic [DATA_W-1:0]         o_wr_data,
    input  logic                      i_rsv_valid,
    input  logic [ADDR_W-1:0]         i_rsv_addr,
    output logic [(1<<ADDR_W)-1:0]    o_pending
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int NREG  = 1 << ADDR_W;

    logic [IDX_W-1:0]   r_ptr;
    logic               r_wr_en;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [DATA_W-1:0]  r_wr_data;

    logic [NUM_REQ-1:0] w_gnt;
    logic [IDX_W-1:0]   w_idx;
    logic               w_any;
    logic               w_xfer;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .i_req   (i_req_valid),
        .i_ptr   (r_ptr),
        .o_gnt   (w_gnt),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // Nothing may transfer while reset is held, so the grant is masked too.
    assign o_req_ready = i_reset ? '0 : w_gnt;
    assign w_xfer      = w_any && !i_reset;
    assign w_sel_addr  = i_req_addr[int'(w_idx)*ADDR_W +: ADDR_W];
    assign w_sel_data  = i_req_data[int'(w_idx)*DATA_W +: DATA_W];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ptr     <= IDX_W'(NUM_REQ - 1);
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            // Writes to $zero are consumed but never reach the register file.
            r_wr_en <= w_xfer && (w_sel_addr != '0);
            if (w_xfer) begin
                r_ptr     <= w_idx;
                r_wr_addr <= w_sel_addr;
                r_wr_data <= w_sel_data;
            end
        end
    end

    assign o_wr_en   = r_wr_en;
    assign o_wr_addr = r_wr_addr;
    assign o_wr_data = r_wr_data;

`ifdef REGFILE_SCOREBOARD_EN
    logic [NREG-1:0] r_pending;
    logic [NREG-1:0] w_pending_nxt;

    // Clear on commit first, then set, so a same-edge re-reservation survives.
    always_comb begin
        w_pending_nxt = r_pending;
        if (r_wr_en) w_pending_nxt[r_wr_addr] = 1'b0;
        if (i_rsv_valid && (i_rsv_addr != '0)) w_pending_nxt[i_rsv_addr] = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) r_pending <= '0;
        else         r_pending <= w_pending_nxt;
    end

    assign o_pending = r_pending;
`else
    logic w_unused_rsv;
    assign w_unused_rsv = ^{i_rsv_valid, i_rsv_addr};
    assign o_pending    = {NREG{1'b0}};
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed and random checks of regfile_write_arbiter against a rule-level model.
// Follows the DUT's REGFILE_SCOREBOARD_EN build for the pending expectations.
module tb_regfile_write_arbiter;
    import regfile_pkg::*;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;
`ifdef REGFILE_SCOREBOARD_EN
    localparam logic SB = 1'b1;
`else
    localparam logic SB = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic            rsv_valid;
    logic [AW-1:0]   rsv_addr;
    logic [31:0]     pending;

    always #5 clk = ~clk;

    regfile_write_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_req_valid (req_valid),
        .i_req_addr  (req_addr),
        .i_req_data  (req_data),
        .o_req_ready (req_ready),
        .o_wr_en     (wr_en),
        .o_wr_addr   (wr_addr),
        .o_wr_data   (wr_data),
        .i_rsv_valid (rsv_valid),
        .i_rsv_addr  (rsv_addr),
        .o_pending   (pending)
    );

    // Requester state and reference model
    logic [N-1:0]  rv;
    logic [AW-1:0] ra [N];
    logic [DW-1:0] rd [N];
    int            m_ptr;
    logic          e_wen;
    logic [AW-1:0] e_waddr;
    logic [DW-1:0] e_wdata;
    logic [31:0]   m_pend;
    logic [DW-1:0] rf [32];
    int            gq [$];
    bit            reload;
    int            n_pass = 0, n_fail = 0, n_tot = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // First valid requester after the last granted one, wrapping around.
    function automatic int exp_grant();
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (rv[j]) return j;
        end
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]           = rv[i];
            req_addr[i*AW +: AW]   = ra[i];
            req_data[i*DW +: DW]   = rd[i];
        end
    endtask

    task automatic cyc();
        int            g;
        logic [N-1:0]  eg;
        logic          s_wen;
        logic [AW-1:0] s_wa;
        logic [DW-1:0] s_wd;
        drive();
        #1;
        g  = reset ? -1 : exp_grant();
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        chk("req_ready", req_ready, eg);
        chk("wr_en", wr_en, e_wen);
        if (e_wen) begin
            chk("wr_addr", wr_addr, e_waddr);
            chk("wr_data", wr_data, e_wdata);
        end
        chk("pending", pending, m_pend);
        s_wen = wr_en; s_wa = wr_addr; s_wd = wr_data;
        @(posedge clk);
        if (s_wen && s_wa != 0) rf[s_wa] = s_wd;
        if (reset) begin
            m_ptr = N - 1; e_wen = 0; e_waddr = 0; e_wdata = 0; m_pend = 0;
        end else begin
            if (SB) begin
                if (e_wen) m_pend[e_waddr] = 1'b0;
                if (rsv_valid && rsv_addr != 0) m_pend[rsv_addr] = 1'b1;
            end
            if (g >= 0) begin
                m_ptr   = g;
                e_wen   = (ra[g] != 0);
                e_waddr = ra[g];
                e_wdata = rd[g];
                gq.push_back(g);
                if (reload) begin
                    ra[g] = AW'($urandom_range(1, 31));
                    rd[g] = $urandom;
                end else begin
                    rv[g] = 1'b0;
                end
            end else begin
                e_wen = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        reset = 1'b1; rsv_valid = 1'b0; rsv_addr = '0; reload = 0;
        rv = '1;
        for (int i = 0; i < N; i++) begin ra[i] = AW'(i + 1); rd[i] = $urandom; end
        drive();
        @(posedge clk);
        @(negedge clk);
        m_ptr = N - 1; e_wen = 0; e_waddr = 0; e_wdata = 0; m_pend = 0;

        // Reset held with every requester valid
        cyc(); cyc();

        // Round-robin with continuously valid requesters
        reset = 1'b0; reload = 1; gq.delete();
        repeat (6) cyc();
        chk("rr_count", gq.size(), 6);
        for (int i = 0; i < 6 && i < gq.size(); i++) chk("rr_order", gq[i], i % 3);
        reload = 0; rv = '0;
        cyc(); cyc();

        // Single ALU write
        gq.delete();
        rv[WB_ALU] = 1'b1; ra[WB_ALU] = 5; rd[WB_ALU] = 32'hDEADBEEF;
        cyc(); cyc();
        chk("single_gnt", gq.size() > 0 ? gq[0] : -1, WB_ALU);
        chk("rf5", rf[5], 32'hDEADBEEF);

        // Load write to $zero is consumed without a write
        gq.delete();
        rv[WB_LOAD] = 1'b1; ra[WB_LOAD] = 0; rd[WB_LOAD] = 32'h1234;
        cyc(); cyc();
        chk("zero_gnt", gq.size() > 0 ? gq[0] : -1, WB_LOAD);
        chk("rf0", rf[0], 0);

        // Scoreboard: reserve 7, write 7 with re-reserve on the commit edge
        rsv_valid = 1'b1; rsv_addr = 7; cyc();
        rsv_valid = 1'b0; cyc();
        chk("pend7_set", pending[7], SB);
        rv[WB_ALU] = 1'b1; ra[WB_ALU] = 7; rd[WB_ALU] = 32'h77; cyc();
        chk("pend7_inflight", pending[7], SB);
        rsv_valid = 1'b1; rsv_addr = 7; cyc();
        rsv_valid = 1'b0; cyc();
        chk("pend7_rereserve", pending[7], SB);
        rv[WB_ALU] = 1'b1; rd[WB_ALU] = 32'h78; cyc(); cyc(); cyc();
        chk("pend7_clear", pending[7], 1'b0);
        rsv_valid = 1'b1; rsv_addr = 0; cyc();
        rsv_valid = 1'b0; cyc();
        chk("pend0_ignored", pending[0], 1'b0);

        // Random traffic with occasional mid-operation reset
        repeat (400) begin
            for (int i = 0; i < N; i++) begin
                if (!rv[i] && $urandom_range(0, 1) == 1) begin
                    rv[i] = 1'b1;
                    ra[i] = AW'($urandom_range(0, 31));
                    rd[i] = $urandom;
                end
            end
            rsv_valid = ($urandom_range(0, 2) == 0);
            rsv_addr  = AW'($urandom_range(0, 31));
            reset     = ($urandom_range(0, 49) == 0);
            cyc();
        end
        reset = 1'b0; rsv_valid = 1'b0; rv = '0;
        cyc(); cyc();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
